// File: rtl/eth_pkg.sv
// Shared Ethernet framing constants, FSM state type and CRC-32 helpers.
// Consumed by the TX FCS inserter and the RX FCS checker.
package eth_pkg;

    localparam logic [31:0] CRC32_INIT    = 32'hFFFFFFFF;
    localparam logic [31:0] CRC32_RESIDUE = 32'hC704DD7B;
    localparam logic [31:0] CRC32_POLY    = 32'h04C11DB7;
    localparam int          ETH_MIN_LEN   = 60;

    typedef enum logic [1:0] {
        ST_DATA = 2'd0,
        ST_PAD  = 2'd1,
        ST_FCS  = 2'd2
    } state_t;

    function automatic logic [31:0] crc32_bitrev(input logic [31:0] v);
        logic [31:0] r;
        for (int i = 0; i < 32; i++) begin
            r[i] = v[31-i];
        end
        return r;
    endfunction

endpackage

// File: rtl/crc32_byte_next.sv
// One-byte CRC-32 step: MSB-first register, polynomial 04C11DB7, data bits fed LSB first.
// Purely combinational, no handshake.
module crc32_byte_next
    import eth_pkg::*;
(
    input  logic [31:0] crc,
    input  logic [7:0]  data,
    output logic [31:0] crc_next
);

    always_comb begin
        crc_next = crc;
        for (int i = 0; i < 8; i++) begin
            if (crc_next[31] ^ data[i]) begin
                crc_next = {crc_next[30:0], 1'b0} ^ CRC32_POLY;
            end else begin
                crc_next = {crc_next[30:0], 1'b0};
            end
        end
    end

endmodule

// File: rtl/eth_tx_fcs_insert.sv
// TX framing: zero-latency frame pass-through, zero pad to MIN_LEN, append 4-byte FCS.
// Downstream i_ready stalls every state; upstream is held off (o_ready=0) during PAD/FCS.
module eth_tx_fcs_insert
    import eth_pkg::*;
#(
    parameter int MIN_LEN = ETH_MIN_LEN,
    parameter int CNT_W   = 16
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic [7:0] i_data,
    input  logic       i_valid,
    input  logic       i_last,
    output logic       o_ready,
    output logic [7:0] o_data,
    output logic       o_valid,
    output logic       o_last,
    input  logic       i_ready,
    output logic       o_busy
);

    localparam logic [CNT_W-1:0] MIN_CNT = CNT_W'(MIN_LEN);

    state_t             state;
    state_t             state_nxt;
    logic [31:0]        crc;
    logic [31:0]        crc_upd;
    logic [31:0]        fcs;
    logic [7:0]         crc_din;
    logic [CNT_W-1:0]   cnt;
    logic [CNT_W-1:0]   cnt_inc;
    logic [1:0]         fcs_idx;
    logic               xfer;

    // PAD and FCS both feed zeros; only the DATA/PAD updates are ever committed.
    assign crc_din = (state == ST_DATA) ? i_data : 8'h00;
    assign fcs     = ~crc32_bitrev(crc);
    assign cnt_inc = (&cnt) ? cnt : cnt + 1'b1;
    assign xfer    = o_valid & i_ready;

    crc32_byte_next u_crc (
        .crc      (crc),
        .data     (crc_din),
        .crc_next (crc_upd)
    );

    always_comb begin
        o_data  = i_data;
        o_valid = 1'b0;
        o_ready = 1'b0;
        o_last  = 1'b0;
        case (state)
            ST_DATA: begin
                o_valid = i_valid;
                o_ready = i_ready;
            end
            ST_PAD: begin
                o_data  = 8'h00;
                o_valid = 1'b1;
            end
            ST_FCS: begin
                o_valid = 1'b1;
                o_last  = (fcs_idx == 2'd3);
                case (fcs_idx)
                    2'd0:    o_data = fcs[7:0];
                    2'd1:    o_data = fcs[15:8];
                    2'd2:    o_data = fcs[23:16];
                    default: o_data = fcs[31:24];
                endcase
            end
            default: ;
        endcase
        // Downstream must never see a beat while reset is held.
        if (i_rst) begin
            o_valid = 1'b0;
            o_ready = 1'b0;
            o_last  = 1'b0;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_DATA: begin
                if (xfer && i_last) begin
                    state_nxt = (cnt_inc < MIN_CNT) ? ST_PAD : ST_FCS;
                end
            end
            ST_PAD: begin
                if (xfer && (cnt_inc == MIN_CNT)) begin
                    state_nxt = ST_FCS;
                end
            end
            ST_FCS: begin
                if (xfer && (fcs_idx == 2'd3)) begin
                    state_nxt = ST_DATA;
                end
            end
            default: state_nxt = ST_DATA;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state <= ST_DATA;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            crc     <= CRC32_INIT;
            cnt     <= '0;
            fcs_idx <= 2'd0;
            o_busy  <= 1'b0;
        end else if (xfer) begin
            case (state)
                ST_DATA: begin
                    crc    <= crc_upd;
                    cnt    <= cnt_inc;
                    o_busy <= 1'b1;
                end
                ST_PAD: begin
                    crc <= crc_upd;
                    cnt <= cnt_inc;
                end
                ST_FCS: begin
                    if (fcs_idx == 2'd3) begin
                        crc     <= CRC32_INIT;
                        cnt     <= '0;
                        fcs_idx <= 2'd0;
                        o_busy  <= 1'b0;
                    end else begin
                        fcs_idx <= fcs_idx + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: doc/eth_tx_fcs_insert.md
Name: eth_tx_fcs_insert

Overview:
- Ethernet TX framing stage; sits directly upstream of the MAC byte serializer.
- Accepts an 8-bit frame byte stream (DA through payload) over a valid/ready handshake and passes it through.
- Zero-pads short frames to MIN_LEN bytes, computes the IEEE 802.3 CRC-32 over all emitted bytes, and appends the 4-byte FCS.

Parameters:
- MIN_LEN, 60, minimum frame length before FCS in bytes; 0 disables padding.
- CNT_W, 16, byte counter width; the counter saturates at all-ones.

Ports:
- i_clk  input  1  clock
- i_rst  input  1  reset, asynchronous, active-high
- i_data  input  8  upstream frame byte
- i_valid  input  1  upstream byte valid
- i_last  input  1  upstream last byte of frame, qualified by i_valid
- o_ready  output  1  upstream may present the next byte
- o_data  output  8  downstream byte
- o_valid  output  1  downstream byte valid
- o_last  output  1  last FCS byte of the frame
- i_ready  input  1  downstream accepts the byte
- o_busy  output  1  high from first accepted byte until the last FCS byte is accepted

Behaviour:
- Transfer rules:
  - A transfer occurs when o_valid and i_ready are both high.
  - An upstream accept occurs when i_valid and o_ready are both high.
  - Once o_valid is raised in PAD/FCS, o_data is held stable until the transfer occurs.
- Reset state: state DATA, crc=32'hFFFFFFFF, cnt=0, fcs_idx=0, o_busy=0. Outputs are combinational from state: o_valid=0 and o_ready=0 during reset; o_last=0.
- DATA state (also the idle state):
  - o_data=i_data, o_valid=i_valid, o_ready=i_ready, o_last=0.
  - Zero-latency combinational pass-through.
  - On each transfer: crc<=next(crc,i_data); cnt<=sat(cnt+1); o_busy<=1.
  - Transfer with i_last: if cnt+1 < MIN_LEN go to PAD, else go to FCS.
- PAD state:
  - o_data=8'h00, o_valid=1, o_ready=0.
  - Each transfer updates crc with 8'h00 and increments cnt.
  - The transfer that makes cnt==MIN_LEN moves the block to FCS.
- FCS state:
  - o_ready=0, o_valid=1, o_data=fcs byte fcs_idx, where fcs=~bitreverse32(crc).
  - Bytes go out LSB first: fcs[7:0], [15:8], [23:16], [31:24].
  - o_last=1 when fcs_idx==3.
  - On the fcs_idx==3 transfer: crc<=FFFFFFFF, cnt<=0, fcs_idx<=0, o_busy<=0, next state DATA.
  - A new frame may be accepted the very next cycle; there is no inter-frame gap inside this block.
- CRC definition:
  - Reflected IEEE 802.3 CRC-32, polynomial 04C11DB7, one byte per cycle.
  - Input byte is processed LSB first; init FFFFFFFF; output is complemented.
  - The PAD/FCS path uses the same next() function as DATA.
- Boundary conditions:
  - cnt saturates at 2^CNT_W-1 and does not wrap; jumbo frames stay legal.
  - A 1-byte frame (i_last on first byte) is legal.
  - i_last without i_valid is ignored.
  - i_ready low in any state stalls the block with no state change.
  - i_valid low in DATA mid-frame inserts idle cycles with no state change.
  - Upstream bytes presented during PAD/FCS are not accepted, since o_ready=0.
  - Reset mid-frame aborts the frame immediately; the downstream sees a truncated frame without o_last.

Decomposition:
- Shared package eth_pkg:
  - constants CRC32_INIT=32'hFFFFFFFF, CRC32_RESIDUE=32'hC704DD7B, ETH_MIN_LEN=60;
  - the state enum {ST_DATA, ST_PAD, ST_FCS}.
- One sub-module, crc32_byte_next:
  - purely combinational next-CRC function (8-bit data, 32-bit state);
  - also reused by the RX FCS checker.
- Counter, state machine and output mux stay in the top module.

Test Plan:
- ASCII "123456789" with MIN_LEN=0, i_ready=1 -> 9 bytes pass through unchanged, then 26 39 F4 CB with o_last on CB; total 13 transfers.
- 1-byte frame 8'hAA with MIN_LEN=60 -> AA followed by 59 bytes of 00, then 4 FCS bytes matching the software model; 64 transfers; o_last only on the 64th.
- 64-byte frame with MIN_LEN=60 -> no PAD bytes; FCS follows byte 64 immediately; re-running the CRC over all 68 emitted bytes yields residue C704DD7B (uncomplemented).
- Random i_ready (50%) and i_valid (70%) gaps over 200 random frames of 1..1518 bytes -> output equals the model byte-for-byte; o_data stable while o_valid && !i_ready.
- Two back-to-back "123456789" frames (MIN_LEN=0) -> the second frame's first byte is accepted the cycle after the first frame's CB transfer; both FCS are 26 39 F4 CB.
- Assert i_rst during the second FCS byte -> o_valid=0 and o_busy=0 while reset is asserted; the next "123456789" frame produces the correct FCS 26 39 F4 CB.
